// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/response bundle plus the data-memory port.
// The sequencer is the slave; the CPU and attached DM form the master side.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] dm_addr;
    logic        dm_W;
    logic        dm_R;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport master (
        output req, we, size, uns, addr, wdata, dm_rdata,
        input  ready, done, err, rdata, dm_addr, dm_W, dm_R, dm_wdata
    );

    modport slave (
        input  req, we, size, uns, addr, wdata, dm_rdata,
        output ready, done, err, rdata, dm_addr, dm_W, dm_R, dm_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store sequencer in front of the DM.
// Sub-word stores run read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RMW_RD,
        RMW_WR
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              err_q;
    logic              accept;
    logic              bad;
    logic              to_acc;

    // Pick the addressed lane of a DM word and sign/zero-extend it.
    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        u
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        unique case (sz)
            2'b00:   r = {{24{b[7] & ~u}}, b};
            2'b01:   r = {{16{h[15] & ~u}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or halfword lane of w with store data.
    function automatic logic [31:0] merge(
        input logic [31:0] w,
        input logic [15:0] d,
        input logic [1:0]  sz,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            unique case (off)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (off[1]) begin
            r[31:16] = d;
        end else begin
            r[15:0] = d;
        end
        return r;
    endfunction

    assign accept = bus.req && (state == IDLE);
    assign to_acc = !bus.we || (bus.size == 2'b10);

    // Reject illegal size, misalignment and addresses past the DM.
    always_comb begin
        bad = 1'b0;
        unique case (bus.size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = bus.addr[0];
            2'b10:   bad = |bus.addr[1:0];
            default: bad = 1'b1;
        endcase
        if (bus.addr >= BYTE_LIMIT) begin
            bad = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && !bad) begin
                    state_nx = to_acc ? ACC : RMW_RD;
                end
            end
            ACC:     state_nx = IDLE;
            RMW_RD:  state_nx = RMW_WR;
            RMW_WR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore strobes: decoded from state only so reset drops them at once.
    always_comb begin
        bus.ready    = 1'b0;
        bus.dm_R     = 1'b0;
        bus.dm_W     = 1'b0;
        bus.dm_wdata = wdata_q;
        unique case (state)
            IDLE: bus.ready = 1'b1;
            ACC: begin
                bus.dm_R = !we_q;
                bus.dm_W = we_q;
            end
            RMW_RD: bus.dm_R = 1'b1;
            RMW_WR: begin
                bus.dm_W     = 1'b1;
                bus.dm_wdata = merged_q;
            end
            default: bus.ready = 1'b0;
        endcase
    end

    // Request latch, merge buffer, load result and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.we;
                        uns_q   <= bus.uns;
                        size_q  <= bus.size;
                        addr_q  <= bus.addr[ADDR_W+1:0];
                        wdata_q <= bus.wdata;
                        if (bad) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    done_q <= 1'b1;
                    if (!we_q) begin
                        rdata_q <= extract(bus.dm_rdata, size_q,
                                           addr_q[1:0], uns_q);
                    end
                end
                RMW_RD: begin
                    merged_q <= merge(bus.dm_rdata, wdata_q[15:0],
                                      size_q, addr_q[1:0]);
                end
                RMW_WR: begin
                    done_q <= 1'b1;
                end
                default: done_q <= 1'b0;
            endcase
        end
    end

    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;
    assign bus.dm_addr = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store traffic against a
// word-array reference memory with byte-lane arithmetic.
module tb_mem_access_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .DEPTH_WORDS(256),
        .ADDR_W     (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rdata;
    logic        bd_we  = 1'b0;
    logic [7:0]  bd_idx = 8'd0;
    logic [31:0] bd_val = 32'd0;
    int n_chk = 0;
    int n_fail = 0;
    int wcyc = 0;
    int rcyc = 0;
    int dcyc = 0;
    int bcyc = 0;

    // Attached DM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (bus.dm_W) mem[bus.dm_addr[7:0]] <= bus.dm_wdata;
        else if (bd_we) mem[bd_idx] <= bd_val;
    end
    assign bus.dm_rdata = bus.dm_R ? mem[bus.dm_addr[7:0]] : 32'h0;

    // Strobe and done cycle counters.
    always @(posedge clk) begin
        if (bus.dm_W) wcyc <= wcyc + 1;
        if (bus.dm_R) rcyc <= rcyc + 1;
        if (bus.done) dcyc <= dcyc + 1;
        if (bus.dm_W && bus.dm_R) bcyc <= bcyc + 1;
    end

    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int xlat, output logic xerr);
        int nb;
        int sh;
        logic [31:0] m;
        logic [31:0] word;
        logic [31:0] v;
        nb = 1 << sz;
        xerr = (sz == 2'd3) || ((a % nb) != 0) || (a >= 32'd1024);
        xlat = 0;
        if (xerr) return;
        sh = int'(a % 4) * 8;
        m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nb * 8)) - 32'd1);
        word = ref_mem[a[9:2]];
        if (!w) begin
            v = (word >> sh) & m;
            if (nb < 4 && !u && v[nb*8-1]) v = v | ~m;
            ref_rdata = v;
            xlat = 1;
        end else begin
            ref_mem[a[9:2]] = (word & ~(m << sh)) | ((d & m) << sh);
            xlat = (nb == 4) ? 1 : 2;
        end
    endtask

    task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic e);
        int k;
        lat = -1;
        e = 1'b0;
        @(negedge clk);
        k = 0;
        while (!bus.ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!bus.ready) begin
            lat = -2;
            return;
        end
        bus.req = 1'b1;
        bus.we = w;
        bus.size = sz;
        bus.uns = u;
        bus.addr = a;
        bus.wdata = d;
        @(posedge clk);
        #1 bus.req = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                e = bus.err;
                break;
            end
        end
    endtask

    task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int xlat,
                          output logic e, output logic xe);
        model(w, sz, u, a, d, xlat, xe);
        do_op(w, sz, u, a, d, lat, e);
    endtask

    task automatic test_reset();
        n_chk++;
        if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus.ready);
        end
        n_chk++;
        if ({bus.done, bus.err, bus.dm_W, bus.dm_R} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {bus.done, bus.err, bus.dm_W, bus.dm_R});
        end
        n_chk++;
        if (bus.rdata !== 32'h0 || bus.dm_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata %h dm_wdata %h want 0",
                     bus.rdata, bus.dm_wdata);
        end
        n_chk++;
        if (bus.dm_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dm_addr: got %h want 0", bus.dm_addr);
        end
    endtask

    task automatic test_word();
        int lat, xlat, w0;
        logic e, xe;
        w0 = wcyc;
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, lat, xlat, e, xe);
        n_chk++;
        if (lat !== 1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_latency: got lat %0d err %b want 1 0", lat, e);
        end
        n_chk++;
        if (wcyc - w0 !== 1) begin
            n_fail++;
            $display("FAIL sw_dmW_cycles: got %0d want 1", wcyc - w0);
        end
        n_chk++;
        if (bus.dm_addr !== 32'd4) begin
            n_fail++;
            $display("FAIL sw_dm_addr: got %h want 4", bus.dm_addr);
        end
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, xlat, e, xe);
        n_chk++;
        if (lat !== 1 || bus.rdata !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL lw_data: got lat %0d rdata %h want 1 11223344",
                     lat, bus.rdata);
        end
    endtask

    task automatic test_subword_store();
        int lat, xlat, w0, r0;
        logic e, xe;
        w0 = wcyc;
        r0 = rcyc;
        run_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, lat, xlat, e, xe);
        n_chk++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL sb_latency: got %0d want 2", lat);
        end
        n_chk++;
        if (mem[4] !== 32'h11AA_3344) begin
            n_fail++;
            $display("FAIL sb_merge: got %h want 11aa3344", mem[4]);
        end
        n_chk++;
        if (wcyc - w0 !== 1 || rcyc - r0 !== 1) begin
            n_fail++;
            $display("FAIL sb_strobes: got W %0d R %0d want 1 1",
                     wcyc - w0, rcyc - r0);
        end
    endtask

    task automatic test_load_ext();
        int lat, xlat;
        logic e, xe;
        logic [31:0] exps [4];
        exps = '{32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_FF80, 32'h0000_0080};
        run_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_8000, lat, xlat, e, xe);
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, (i < 2) ? 2'b01 : 2'b00, 1'(i % 2),
                   (i < 2) ? 32'h20 : 32'h21, 32'h0, lat, xlat, e, xe);
            n_chk++;
            if (bus.rdata !== exps[i] || lat !== 1) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: got %h lat %0d want %h lat 1",
                         i, bus.rdata, lat, exps[i]);
            end
        end
    endtask

    task automatic test_reject();
        int lat, xlat, w0, r0;
        logic e, xe;
        logic [31:0] rd0, m8;
        logic [1:0]  szs [4];
        logic [31:0] as  [4];
        logic        ws  [4];
        szs = '{2'b01, 2'b10, 2'b11, 2'b10};
        as  = '{32'h21, 32'h22, 32'h08, 32'h400};
        ws  = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            w0 = wcyc;
            r0 = rcyc;
            rd0 = bus.rdata;
            m8 = mem[8];
            run_op(ws[i], szs[i], 1'b0, as[i], 32'hDEAD_BEEF,
                   lat, xlat, e, xe);
            @(negedge clk);
            n_chk++;
            if (e !== 1'b1 || lat !== 0) begin
                n_fail++;
                $display("FAIL reject[%0d]: got err %b lat %0d want 1 0",
                         i, e, lat);
            end
            n_chk++;
            if (wcyc != w0 || rcyc != r0 || bus.rdata !== rd0
                || mem[8] !== m8 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_side[%0d]: W %0d R %0d rdata %h dm %h done %b",
                         i, wcyc - w0, rcyc - r0, bus.rdata, mem[8], bus.done);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat, xlat, d0;
        logic e, xe;
        run_op(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_BABE, lat, xlat, e, xe);
        @(negedge clk);
        bus.req = 1'b1;
        bus.we = 1'b1;
        bus.size = 2'b00;
        bus.uns = 1'b0;
        bus.addr = 32'h30;
        bus.wdata = 32'h55;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.dm_W !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_rmw_wr: dm_W %b want 1", bus.dm_W);
        end
        d0 = dcyc;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.dm_W !== 1'b0 || bus.dm_R !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_strobe: W %b R %b want 0 0",
                     bus.dm_W, bus.dm_R);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_rdata = 32'h0;
        @(negedge clk);
        n_chk++;
        if (mem[12] !== 32'hCAFE_BABE || dcyc != d0) begin
            n_fail++;
            $display("FAIL abort_dm: got %h dones %0d want cafebabe 0",
                     mem[12], dcyc - d0);
        end
        n_chk++;
        if (bus.ready !== 1'b1 || bus.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_release: ready %b rdata %h want 1 0",
                     bus.ready, bus.rdata);
        end
    endtask

    task automatic test_busy_req();
        int xlat;
        logic xe;
        logic [9:0] mask;
        logic [31:0] rd_a, exp_a;
        model(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, xlat, xe);
        exp_a = ref_rdata;
        model(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_1234, xlat, xe);
        mask = '0;
        rd_a = '0;
        @(negedge clk);
        bus.req = 1'b1;
        bus.we = 1'b0;
        bus.size = 2'b10;
        bus.uns = 1'b0;
        bus.addr = 32'h30;
        bus.wdata = 32'h0;
        @(posedge clk);
        #1;
        bus.we = 1'b1;
        bus.size = 2'b01;
        bus.addr = 32'h32;
        bus.wdata = 32'h0000_1234;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            mask[k] = bus.done;
            if (k == 1) rd_a = bus.rdata;
            if (k == 2) bus.req = 1'b0;
        end
        n_chk++;
        if (mask !== 10'h012) begin
            n_fail++;
            $display("FAIL busy_done_pattern: got %b want 0000010010", mask);
        end
        n_chk++;
        if (rd_a !== exp_a) begin
            n_fail++;
            $display("FAIL busy_load: got %h want %h", rd_a, exp_a);
        end
        n_chk++;
        if (mem[12] !== ref_mem[12] || mem[12] !== 32'h1234_BABE) begin
            n_fail++;
            $display("FAIL busy_store: got %h want 1234babe", mem[12]);
        end
    endtask

    task automatic test_random();
        int lat, xlat, mm;
        logic e, xe, w, u;
        logic [1:0] sz;
        logic [31:0] a, d;
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom % 2);
            u = 1'($urandom % 2);
            sz = 2'($urandom % 4);
            a = 32'(($urandom % 16) * 4 + ($urandom % 4));
            if ($urandom % 10 == 0) a = a | 32'h400;
            d = $urandom;
            run_op(w, sz, u, a, d, lat, xlat, e, xe);
            n_chk++;
            if (lat !== xlat || e !== xe || bus.rdata !== ref_rdata) begin
                n_fail++;
                $display("FAIL rand[%0d] we%b sz%0d u%b a%h: lat %0d err %b rdata %h want %0d %b %h",
                         i, w, sz, u, a, lat, e, bus.rdata, xlat, xe, ref_rdata);
            end
        end
        mm = 0;
        for (int j = 0; j < 256; j++) begin
            if (mem[j] !== ref_mem[j]) mm++;
        end
        n_chk++;
        if (mm !== 0) begin
            n_fail++;
            $display("FAIL rand_mem: got %0d differing words want 0", mm);
        end
        n_chk++;
        if (bcyc !== 0) begin
            n_fail++;
            $display("FAIL both_strobes: got %0d cycles want 0", bcyc);
        end
    endtask

    initial begin
        bus.req = 1'b0;
        bus.we = 1'b0;
        bus.size = 2'b00;
        bus.uns = 1'b0;
        bus.addr = 32'h0;
        bus.wdata = 32'h0;
        ref_rdata = 32'h0;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bd_idx = 8'(i);
            bd_val = $urandom;
            ref_mem[i] = bd_val;
            bd_we = 1'b1;
        end
        @(negedge clk);
        bd_we = 1'b0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_word();
        test_subword_store();
        test_load_ext();
        test_reject();
        test_reset_abort();
        test_busy_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
